// File: rtl/absorb_feeder_pkg.sv
// Shared Keccak definitions: lane/rate geometry, domain-separation bytes, feeder states.
package absorb_feeder_pkg;

    localparam int LANE_W     = 64;
    localparam int RATE_WORDS = 21;

    localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
    localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;

    typedef enum logic [1:0] {
        ST_ABSORB    = 2'd0,
        ST_PAD       = 2'd1,
        ST_WAIT_PERM = 2'd2,
        ST_DONE      = 2'd3
    } feed_state_e;

endpackage

// File: rtl/absorb_feeder_if.sv
// Message-in / SIPO-out / permutation handshake bundle for the absorb feeder.
interface absorb_feeder_if;
    import absorb_feeder_pkg::*;

    logic [LANE_W-1:0] msg_data;
    logic              msg_valid;
    logic              msg_last;
    logic [3:0]        msg_bytes;
    logic              msg_ready;
    logic [LANE_W-1:0] data_in;
    logic              load_en;
    logic              cntr_zero;
    logic              block_valid;
    logic              block_last;
    logic              perm_done;

    modport master (
        output msg_data, msg_valid, msg_last, msg_bytes, perm_done,
        input  msg_ready, data_in, load_en, cntr_zero, block_valid, block_last
    );

    modport slave (
        input  msg_data, msg_valid, msg_last, msg_bytes, perm_done,
        output msg_ready, data_in, load_en, cntr_zero, block_valid, block_last
    );
endinterface

// File: rtl/absorb_feeder_pad_word.sv
// Byte-merge for the final message word: keeps n bytes, drops the domain byte at
// position n, zero-fills above, and optionally sets the closing 0x80 in byte 7.
module pad_word
    import absorb_feeder_pkg::*;
(
    input  logic [LANE_W-1:0] word_in,
    input  logic [3:0]        n,
    input  logic [7:0]        domain,
    input  logic              last_flag,
    output logic [LANE_W-1:0] word_out
);

    always_comb begin
        word_out = '0;
        for (int k = 0; k < LANE_W/8; k++) begin
            if (4'(k) < n)
                word_out[8*k +: 8] = word_in[8*k +: 8];
            else if (4'(k) == n)
                word_out[8*k +: 8] = domain;
        end
        if (last_flag)
            word_out[LANE_W-1] = 1'b1;
    end

endmodule

// File: rtl/absorb_feeder.sv
// Feeds message words into the Keccak SIPO loader, applying pad10*1 with the
// domain byte and sequencing rate blocks against the permutation handshake.
module absorb_feeder
    import absorb_feeder_pkg::*;
#(
    parameter logic [7:0] DOMAIN = DOMAIN_SHA3,
    parameter int         WORDS  = RATE_WORDS
) (
    input logic            clk,
    input logic            hash_init,
    absorb_feeder_if.slave bus
);

    localparam logic [1:0] ABSORB    = ST_ABSORB;
    localparam logic [1:0] PAD       = ST_PAD;
    localparam logic [1:0] WAIT_PERM = ST_WAIT_PERM;
    localparam logic [1:0] DONE      = ST_DONE;
    localparam logic [4:0] WCNT_INIT = 5'(WORDS - 1);

    function automatic logic [3:0] sat_bytes(input logic [3:0] n);
        return (n > 4'd8) ? 4'd8 : n;
    endfunction

    logic [1:0]        state;
    logic [4:0]        wcnt;
    logic              dom_pend;
    logic              pad_blk_pend;
    logic              last_blk;
    logic              block_valid_r;
    logic              block_last_r;

    logic              in_absorb, in_pad, wz, load_en, cntr_zero;
    logic              short_last, pad_end;
    logic [3:0]        n_sat, pw_n;
    logic [7:0]        pw_dom;
    logic [LANE_W-1:0] pw_word, data_w;

    // Outputs are gated by hash_init so an abort silences the loader at once.
    always_comb begin
        n_sat      = sat_bytes(bus.msg_bytes);
        wz         = (wcnt == 5'd0);
        in_absorb  = (state == ABSORB) && !hash_init;
        in_pad     = (state == PAD) && !hash_init;
        load_en    = (in_absorb && bus.msg_valid) || in_pad;
        cntr_zero  = load_en && wz;
        short_last = bus.msg_last && (n_sat != 4'd8);
        pad_end    = cntr_zero && (in_pad || short_last);
        pw_word    = in_pad ? '0 : bus.msg_data;
        pw_n       = in_pad ? 4'd0 : (bus.msg_last ? n_sat : 4'd8);
        pw_dom     = (in_pad && !dom_pend) ? 8'h00 : DOMAIN;
    end

    pad_word u_pad (
        .word_in  (pw_word),
        .n        (pw_n),
        .domain   (pw_dom),
        .last_flag(pad_end),
        .word_out (data_w)
    );

    assign bus.msg_ready   = in_absorb;
    assign bus.load_en     = load_en;
    assign bus.cntr_zero   = cntr_zero;
    assign bus.data_in     = data_w;
    assign bus.block_valid = block_valid_r;
    assign bus.block_last  = block_last_r;

    always_ff @(posedge clk or posedge hash_init) begin
        if (hash_init) begin
            state         <= ABSORB;
            wcnt          <= WCNT_INIT;
            dom_pend      <= 1'b0;
            pad_blk_pend  <= 1'b0;
            last_blk      <= 1'b0;
            block_valid_r <= 1'b0;
            block_last_r  <= 1'b0;
        end else begin
            block_valid_r <= cntr_zero;
            block_last_r  <= pad_end;
            if (load_en)
                wcnt <= wz ? WCNT_INIT : 5'(wcnt - 5'd1);

            case (state)
                ABSORB: begin
                    if (load_en && bus.msg_last) begin
                        // A full last word defers the domain byte to the next pad word.
                        dom_pend <= !short_last;
                        if (wz) begin
                            state        <= WAIT_PERM;
                            last_blk     <= short_last;
                            pad_blk_pend <= !short_last;
                        end else begin
                            state <= PAD;
                        end
                    end else if (cntr_zero) begin
                        state    <= WAIT_PERM;
                        last_blk <= 1'b0;
                    end
                end
                PAD: begin
                    dom_pend <= 1'b0;
                    if (wz) begin
                        state    <= WAIT_PERM;
                        last_blk <= 1'b1;
                    end
                end
                WAIT_PERM: begin
                    if (bus.perm_done) begin
                        if (last_blk) begin
                            state <= DONE;
                        end else if (pad_blk_pend) begin
                            state        <= PAD;
                            pad_blk_pend <= 1'b0;
                        end else begin
                            state <= ABSORB;
                        end
                    end
                end
                default: state <= DONE;
            endcase
        end
    end

endmodule

// File: tb/tb_absorb_feeder.sv
// Scoreboard bench for absorb_feeder: directed messages, expected loads queued at issue.
module tb_absorb_feeder;

    logic clk = 1'b0;
    logic hash_init = 1'b1;

    absorb_feeder_if bus ();

    absorb_feeder #(.DOMAIN(8'h06), .WORDS(21)) dut (
        .clk      (clk),
        .hash_init(hash_init),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        cz;
    } exp_t;

    exp_t wq[$];
    logic bq[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [63:0] PAD_END = 64'h8000_0000_0000_0000;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic exp_w(input logic [63:0] d, input logic cz);
        exp_t e;
        e.d  = d;
        e.cz = cz;
        wq.push_back(e);
    endtask

    task automatic exp_zeros(input int count);
        for (int i = 0; i < count; i++) exp_w(64'h0, 1'b0);
    endtask

    task automatic send(input logic [63:0] d, input logic last, input logic [3:0] n);
        int t = 0;
        while (bus.msg_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) chk("msg_ready_timeout", bus.msg_ready, 1);
        bus.msg_data  = d;
        bus.msg_valid = 1'b1;
        bus.msg_last  = last;
        bus.msg_bytes = n;
        @(posedge clk); #1;
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
        bus.msg_bytes = 4'd0;
    endtask

    task automatic send_full(input int count, input logic [63:0] base, input int start_idx);
        for (int i = 0; i < count; i++) begin
            exp_w(base + 64'(i), (start_idx + i) == 20);
            send(base + 64'(i), 1'b0, 4'd0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_perm();
        bus.perm_done = 1'b1;
        @(posedge clk); #1;
        bus.perm_done = 1'b0;
    endtask

    task automatic do_perm();
        int t = 0;
        while (t < 100) begin
            @(negedge clk);
            if (bus.block_valid === 1'b1) break;
            t++;
        end
        if (t >= 100) chk("block_valid_timeout", bus.block_valid, 1);
        @(posedge clk); #1;
        pulse_perm();
    endtask

    task automatic reset_pulse();
        hash_init = 1'b1;
        @(posedge clk); #1;
        hash_init = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.msg_data  = '0;
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
        bus.msg_bytes = 4'd0;
        bus.perm_done = 1'b0;
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (bus.load_en === 1'b1) begin
                        if (wq.size() == 0) begin
                            chk("load_en_unexpected", bus.load_en, 0);
                        end else begin
                            e = wq.pop_front();
                            chk("data_in", bus.data_in, e.d);
                            chk("cntr_zero", bus.cntr_zero, e.cz);
                        end
                    end else if (bus.cntr_zero !== 1'b0) begin
                        chk("cntr_zero_idle", bus.cntr_zero, 0);
                    end
                    if (bus.block_valid === 1'b1) begin
                        if (bq.size() == 0) chk("block_valid_unexpected", bus.block_valid, 0);
                        else                chk("block_last", bus.block_last, bq.pop_front());
                    end
                end
            end
            begin : stimulus
                // Reset: outputs quiet even with a word offered
                repeat (3) @(posedge clk);
                #1 bus.msg_valid = 1'b1;
                @(negedge clk);
                chk("rst_msg_ready", bus.msg_ready, 0);
                chk("rst_load_en", bus.load_en, 0);
                chk("rst_cntr_zero", bus.cntr_zero, 0);
                chk("rst_block_valid", bus.block_valid, 0);
                chk("rst_block_last", bus.block_last, 0);
                bus.msg_valid = 1'b0;
                @(posedge clk); #1;
                hash_init = 1'b0;
                #1 chk("release_msg_ready", bus.msg_ready, 1);
                @(posedge clk); #1;

                // Full block, then last word n=3 padded into a second block
                send_full(21, 64'h0101_0000_0000_0000, 0);
                bq.push_back(1'b0);
                do_perm();
                exp_w(64'h0000_0000_0633_2211, 1'b0);
                exp_zeros(19);
                exp_w(PAD_END, 1'b1);
                bq.push_back(1'b1);
                send(64'hDEAD_BEEF_DE33_2211, 1'b1, 4'd3);
                do_perm();
                bus.msg_valid = 1'b1;
                idle(3);
                chk("done_msg_ready", bus.msg_ready, 0);
                bus.msg_valid = 1'b0;
                reset_pulse();

                // Last word n=7 at word 20: domain and pad end share byte 7
                send_full(20, 64'h0202_0000_0000_0000, 0);
                exp_w(64'h8622_3344_5566_7788, 1'b1);
                bq.push_back(1'b1);
                send(64'h1122_3344_5566_7788, 1'b1, 4'd7);
                do_perm();
                idle(2);
                chk("done2_msg_ready", bus.msg_ready, 0);
                reset_pulse();

                // Last word n=8 fills word 20: unpadded block, then whole pad block
                send_full(20, 64'h0303_0000_0000_0000, 0);
                exp_w(64'hCAFE_0000_1234_5678, 1'b1);
                bq.push_back(1'b0);
                exp_w(64'h0000_0000_0000_0006, 1'b0);
                exp_zeros(19);
                exp_w(PAD_END, 1'b1);
                bq.push_back(1'b1);
                send(64'hCAFE_0000_1234_5678, 1'b1, 4'd8);
                do_perm();
                do_perm();
                idle(2);
                chk("done3_msg_ready", bus.msg_ready, 0);
                reset_pulse();

                // Stray perm_done, a 5-cycle stall, then WAIT_PERM holds
                send_full(10, 64'h0404_0000_0000_0000, 0);
                pulse_perm();
                chk("stray_perm_msg_ready", bus.msg_ready, 1);
                idle(5);
                send_full(11, 64'h0404_0000_0000_000A, 10);
                bq.push_back(1'b0);
                idle(6);
                chk("wait_perm_hold", bus.msg_ready, 0);
                pulse_perm();
                chk("after_perm_msg_ready", bus.msg_ready, 1);

                // msg_bytes=15 saturates to 8: word 0 passes, domain goes to word 1
                exp_w(64'h0123_4567_89AB_CDEF, 1'b0);
                exp_w(64'h0000_0000_0000_0006, 1'b0);
                exp_zeros(18);
                exp_w(PAD_END, 1'b1);
                bq.push_back(1'b1);
                send(64'h0123_4567_89AB_CDEF, 1'b1, 4'd15);
                do_perm();
                idle(2);
                chk("done4_msg_ready", bus.msg_ready, 0);
                reset_pulse();

                // hash_init while PAD presents word 10, then a fresh block
                exp_w(64'h0000_0000_0000_0006, 1'b0);
                exp_zeros(9);
                send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
                idle(9);
                hash_init = 1'b1;
                @(negedge clk);
                chk("abort_load_en", bus.load_en, 0);
                chk("abort_queue_left", wq.size(), 0);
                @(posedge clk); #1;
                hash_init = 1'b0;
                @(posedge clk); #1;
                send_full(21, 64'h0505_0000_0000_0000, 0);
                bq.push_back(1'b0);
                do_perm();
                chk("restart_msg_ready", bus.msg_ready, 1);

                idle(2);
                chk("word_queue_drained", wq.size(), 0);
                chk("block_queue_drained", bq.size(), 0);
            end
            begin : watchdog
                #200000;
                total++;
                bad++;
                $display("FAIL watchdog: bench still running at %0t", $time);
            end
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
